// File: rtl/spram_gen.sv
// spram_gen: generic single-port RAM with zero-fill sweep and
// selectable read latency / write-collision behaviour.
//
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous, active-high
//   ce    - access enable (ignored while busy)
//   oce   - output register enable (READ_MODE=1 only)
//   wre   - 1 = write, 0 = read, qualified by ce
//   ad    - word address
//   din   - write data
//   clr   - single-cycle request to re-run the zero-fill sweep
//   dout  - read data
//   busy  - high while the sweep runs; accesses are ignored
module spram_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int READ_MODE  = 0,
  parameter int WRITE_MODE = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  oce,
  input  logic                  wre,
  input  logic [ADDR_WIDTH-1:0] ad,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST =
    (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE =
    (ADDR_WIDTH+1)'(1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;

  logic                  acc;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;

  // clr wins over a same-cycle access
  assign acc = ~busy & ce & ~clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      if (INIT_CLEAR != 0) begin
        state <= CLEAR;
        busy  <= 1'b1;
      end else begin
        state <= READY;
        busy  <= 1'b0;
      end
    end else begin
      unique case (state)
        CLEAR: begin
          if (cnt == LAST) begin
            state <= READY;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        READY: begin
          if (clr) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  // Reset held across an edge must not let the
  // sweep port scribble address 0.
  assign mem_we = ~reset & (busy | (acc & wre));
  assign mem_wa = busy ? cnt[ADDR_WIDTH-1:0] : ad;
  assign mem_wd = busy ? '0 : din;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
    end else if (acc) begin
      if (!wre) begin
        rd_q <= mem[ad];
      end else if (WRITE_MODE == 1) begin
        rd_q <= din;
      end else if (WRITE_MODE == 2) begin
        rd_q <= mem[ad];
      end
    end
  end

  generate
    if (READ_MODE == 1) begin : g_pipe
      logic [DATA_WIDTH-1:0] out_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          out_q <= '0;
        end else if (oce & ~busy) begin
          out_q <= rd_q;
        end
      end

      assign dout = out_q;
    end else begin : g_bypass
      logic oce_unused;

      assign oce_unused = oce;
      assign dout       = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_spram_gen.sv
// tb_spram_gen: scoreboard bench driving four spram_gen
// configurations from one shared directed stimulus stream.
module tb_spram_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       oce;
  logic       wre;
  logic [1:0] ad;
  logic [7:0] din;
  logic       clr;

  logic [3:0][7:0] dout_w;
  logic [3:0]      busy_w;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         due;
    int         dut;
    bit         is_busy;
    logic [7:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  spram_gen #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2),
    .READ_MODE(0), .WRITE_MODE(0), .INIT_CLEAR(1)
  ) u_a (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce),
    .wre(wre), .ad(ad), .din(din), .clr(clr),
    .dout(dout_w[0]), .busy(busy_w[0])
  );

  spram_gen #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2),
    .READ_MODE(0), .WRITE_MODE(2), .INIT_CLEAR(1)
  ) u_b (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce),
    .wre(wre), .ad(ad), .din(din), .clr(clr),
    .dout(dout_w[1]), .busy(busy_w[1])
  );

  spram_gen #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2),
    .READ_MODE(1), .WRITE_MODE(1), .INIT_CLEAR(1)
  ) u_c (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce),
    .wre(wre), .ad(ad), .din(din), .clr(clr),
    .dout(dout_w[2]), .busy(busy_w[2])
  );

  spram_gen #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2),
    .READ_MODE(0), .WRITE_MODE(0), .INIT_CLEAR(0)
  ) u_d (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce),
    .wre(wre), .ad(ad), .din(din), .clr(clr),
    .dout(dout_w[3]), .busy(busy_w[3])
  );

  always @(negedge clk) begin
    exp_t       keep[$];
    logic [7:0] act;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].due == cyc) begin
        act = sb[i].is_busy ? {7'b0, busy_w[sb[i].dut]}
                            : dout_w[sb[i].dut];
        checks++;
        if (act !== sb[i].v) begin
          errors++;
          $display("FAIL %s dut%0d cyc%0d: got %h want %h",
                   sb[i].tag, sb[i].dut, cyc, act, sb[i].v);
        end
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic drv(input bit c, input bit w,
                     input logic [1:0] a, input logic [7:0] d,
                     input bit o, input bit cl);
    @(negedge clk);
    ce  = c;
    wre = w;
    ad  = a;
    din = d;
    oce = o;
    clr = cl;
  endtask

  task automatic ed(input int dut, input int off,
                    input logic [7:0] v, input string t);
    exp_t e;
    e.due     = cyc + off;
    e.dut     = dut;
    e.is_busy = 1'b0;
    e.v       = v;
    e.tag     = t;
    sb.push_back(e);
  endtask

  task automatic eb(input int dut, input int off,
                    input bit v, input string t);
    exp_t e;
    e.due     = cyc + off;
    e.dut     = dut;
    e.is_busy = 1'b1;
    e.v       = {7'b0, v};
    e.tag     = t;
    sb.push_back(e);
  endtask

  task automatic abc_busy(input int off, input bit v,
                          input string t);
    for (int d = 0; d < 3; d++) eb(d, off, v, t);
  endtask

  initial begin
    reset = 1'b1;
    ce = 0; wre = 0; ad = 0; din = 0; oce = 0; clr = 0;

    drv(0, 0, 0, 8'h00, 0, 0);
    checks++;
    if (dout_w[0] !== 8'h00 || busy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_direct_a: dout %h busy %b",
               dout_w[0], busy_w[0]);
    end
    checks++;
    if (dout_w[2] !== 8'h00 || busy_w[3] !== 1'b0) begin
      errors++;
      $display("FAIL rst_direct_cd: dout %h busy %b",
               dout_w[2], busy_w[3]);
    end
    for (int d = 0; d < 4; d++) ed(d, 1, 8'h00, "rst_dout");
    abc_busy(1, 1, "rst_busy");
    eb(3, 1, 0, "rst_busy_ic0");

    drv(1, 1, 0, 8'hEE, 1, 0);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) abc_busy(k, 1, "sweep_busy");
    abc_busy(4, 0, "sweep_done");
    eb(3, 1, 0, "ic0_ready");
    for (int d = 0; d < 4; d++) ed(d, 4, 8'h00, "sweep_hold");
    repeat (3) drv(1, 1, 0, 8'hEE, 1, 0);

    for (int k = 0; k < 4; k++) begin
      drv(1, 0, 2'(k), 8'h00, 1, 0);
      ed(0, 1, 8'h00, "init_rd");
      ed(1, 1, 8'h00, "init_rd");
      ed(2, 2, 8'h00, "init_rd_pipe");
      if (k == 0) ed(3, 1, 8'hEE, "ic0_rd");
    end

    drv(1, 1, 1, 8'hA5, 1, 0);
    ed(0, 1, 8'h00, "wr_hold");
    ed(1, 1, 8'h00, "rbw_old");
    ed(2, 2, 8'hA5, "wt_a5");

    drv(1, 0, 1, 8'h00, 1, 0);
    ed(0, 1, 8'hA5, "rd_a5");
    ed(1, 1, 8'hA5, "rd_a5");
    ed(2, 2, 8'hA5, "rd_a5_pipe");

    drv(1, 1, 2, 8'h3C, 1, 0);
    ed(0, 1, 8'hA5, "wr_hold2");
    ed(1, 1, 8'h00, "rbw_old2");
    ed(2, 2, 8'h3C, "wt_3c");

    drv(1, 1, 2, 8'h5A, 1, 0);
    ed(0, 1, 8'hA5, "wr_hold3");
    ed(1, 1, 8'h3C, "rbw_3c");
    ed(2, 2, 8'h5A, "wt_5a");

    drv(1, 0, 2, 8'h00, 1, 0);
    ed(0, 1, 8'h5A, "rd_5a");
    ed(1, 1, 8'h5A, "rd_5a");
    ed(2, 2, 8'h5A, "rd_5a_pipe");

    drv(1, 1, 3, 8'h77, 1, 0);
    ed(0, 1, 8'h5A, "wr_hold4");
    ed(1, 1, 8'h00, "rbw_old3");
    ed(2, 2, 8'h77, "wt_77");
    drv(0, 0, 0, 8'h00, 1, 0);

    drv(1, 1, 3, 8'h44, 0, 0);
    ed(0, 1, 8'h5A, "wr_hold5");
    ed(1, 1, 8'h77, "rbw_77");
    ed(2, 1, 8'h77, "oce0_hold");
    drv(0, 0, 0, 8'h00, 0, 0);
    ed(2, 1, 8'h77, "oce0_hold2");
    drv(0, 0, 0, 8'h00, 1, 0);
    ed(0, 1, 8'h5A, "idle_hold");
    ed(1, 1, 8'h77, "idle_hold");
    ed(2, 1, 8'h44, "oce1_load");

    drv(1, 1, 0, 8'hFF, 1, 0);
    ed(0, 1, 8'h5A, "wr_ff_hold");
    ed(1, 1, 8'h00, "rbw_old4");
    ed(2, 2, 8'hFF, "wt_ff");

    drv(1, 1, 0, 8'h11, 1, 1);
    for (int k = 1; k <= 4; k++) abc_busy(k, 1, "clr_busy");
    abc_busy(5, 0, "clr_done");
    ed(0, 5, 8'h5A, "clr_hold");
    ed(1, 1, 8'h00, "clr_drop_rbw");
    ed(1, 5, 8'h00, "clr_hold_rbw");
    ed(2, 5, 8'hFF, "clr_drop_wt");
    repeat (4) drv(1, 1, 0, 8'h11, 1, 1);

    drv(1, 0, 0, 8'h00, 1, 0);
    ed(0, 1, 8'h00, "clr_rd0");
    ed(1, 1, 8'h00, "clr_rd0");
    ed(2, 1, 8'hFF, "clr_drop_pipe");
    ed(2, 2, 8'h00, "clr_rd0_pipe");

    drv(1, 1, 1, 8'h99, 1, 0);
    ed(0, 1, 8'h00, "wr99_hold");
    ed(1, 1, 8'h00, "rbw_old5");
    ed(2, 2, 8'h99, "wt_99");
    drv(1, 0, 1, 8'h00, 1, 0);
    ed(0, 1, 8'h99, "rd_99");
    ed(1, 1, 8'h99, "rd_99");
    ed(2, 2, 8'h99, "rd_99_pipe");

    drv(0, 0, 0, 8'h00, 1, 1);
    abc_busy(1, 1, "sweep2_busy");
    abc_busy(2, 1, "sweep2_busy");
    ed(0, 2, 8'h99, "sweep2_hold");
    ed(1, 2, 8'h99, "sweep2_hold");
    drv(0, 0, 0, 8'h00, 1, 0);
    drv(0, 0, 0, 8'h00, 1, 0);
    for (int d = 0; d < 4; d++) ed(d, 1, 8'h00, "async_rst");
    abc_busy(1, 1, "midrst_busy");
    eb(3, 1, 0, "midrst_ic0");
    @(posedge clk);
    #2 reset = 1'b1;
    drv(0, 0, 0, 8'h00, 1, 0);
    drv(0, 0, 0, 8'h00, 1, 0);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) abc_busy(k, 1, "restart_busy");
    abc_busy(4, 0, "restart_done");
    eb(3, 1, 0, "restart_ic0");
    repeat (3) drv(0, 0, 0, 8'h00, 1, 0);

    for (int k = 1; k <= 2; k++) begin
      drv(1, 0, 2'(k), 8'h00, 1, 0);
      ed(0, 1, 8'h00, "post_rst_rd");
      ed(1, 1, 8'h00, "post_rst_rd");
      ed(2, 2, 8'h00, "post_rst_rd_pipe");
    end
    repeat (3) drv(0, 0, 0, 8'h00, 1, 0);

    checks++;
    if (busy_w[2:0] !== 3'b000) begin
      errors++;
      $display("FAIL end_busy: got %b", busy_w[2:0]);
    end
    checks++;
    if (dout_w[0] !== 8'h00 || dout_w[2] !== 8'h00) begin
      errors++;
      $display("FAIL end_dout: got %h %h",
               dout_w[0], dout_w[2]);
    end

    foreach (sb[i]) begin
      errors++;
      $display("FAIL %s dut%0d: got unchecked want due %0d",
               sb[i].tag, sb[i].dut, sb[i].due);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
